// File: rtl/clk_mon_pkg.sv
// Shared encodings and helpers for the clock-rate health checker.
// State/class enums, the "not yet measured" marker and the tolerance-window helpers.
package clk_mon_pkg;

    typedef enum logic [2:0] {
        ST_UNKNOWN = 3'd0,
        ST_LOCKING = 3'd1,
        ST_GOOD    = 3'd2,
        ST_BAD     = 3'd3,
        ST_DEAD    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_INVALID = 2'd0,
        CLS_ZERO    = 2'd1,
        CLS_INRANGE = 2'd2,
        CLS_OOR     = 2'd3
    } class_t;

    localparam logic [31:0] RATE_UNMEASURED = 32'hFFFF_FFFF;

    localparam int                CTR_W   = 4;
    localparam logic [CTR_W-1:0]  CTR_MAX = 4'd15;

    // Window edges are 33 bits wide so EXP+TOL cannot wrap; LO clamps at zero.
    function automatic logic [32:0] window_lo(input logic [31:0] exp_count,
                                              input logic [31:0] tol_count);
        return (exp_count < tol_count) ? 33'd0
                                       : ({1'b0, exp_count} - {1'b0, tol_count});
    endfunction

    function automatic logic [32:0] window_hi(input logic [31:0] exp_count,
                                              input logic [31:0] tol_count);
        return {1'b0, exp_count} + {1'b0, tol_count};
    endfunction

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] value);
        return (value == CTR_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/clk_rate_classify.sv
// Classifies one rate sample against the [lo, hi] window and registers the result.
// The registered valid flag marks the evaluation cycle for the checker FSM.
module clk_rate_classify
    import clk_mon_pkg::*;
(
    input  logic        clk100,
    input  logic        async_reset_clktest,
    input  logic        sample_en,
    input  logic [31:0] sample,
    input  logic [32:0] lo,
    input  logic [32:0] hi,
    output logic        valid,
    output logic [31:0] sample_q,
    output class_t      sample_class
);

    class_t cls;

    always_comb begin
        // NOTE: assign a default first so no path through the block can infer a latch.
        cls = CLS_OOR;
        if (sample == RATE_UNMEASURED) begin
            cls = CLS_INVALID;
        end else if (sample == '0) begin
            cls = CLS_ZERO;
        end else if (({1'b0, sample} >= lo) && ({1'b0, sample} <= hi)) begin
            cls = CLS_INRANGE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments and the async reset sits in the sensitivity list.
    always_ff @(posedge clk100 or posedge async_reset_clktest) begin
        if (async_reset_clktest) begin
            valid        <= 1'b0;
            sample_q     <= '0;
            sample_class <= CLS_INVALID;
        end else begin
            valid <= sample_en;
            if (sample_en) begin
                sample_q     <= sample;
                sample_class <= cls;
            end
        end
    end

endmodule

// File: rtl/clk_rate_checker.sv
// Periodic clock-rate health checker: samples the rate word, debounces GOOD/BAD/DEAD, keeps sticky flags.
// Optional CLK_RATE_MINMAX_EN adds min_count/max_count trackers of all valid samples.
module clk_rate_checker
    import clk_mon_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 8388609,
    parameter int unsigned EXP_COUNT     = 1000000,
    parameter int unsigned TOL_COUNT     = 10000,
    parameter int unsigned GOOD_N        = 3,
    parameter int unsigned BAD_N         = 2
)
(
    input  logic        clk100,
    input  logic        async_reset_clktest,
    input  logic [31:0] value_in,
    input  logic        clear_sticky,
    output logic        clk_ok,
    output logic        clk_dead,
    output logic [2:0]  state,
    output logic [31:0] last_count,
    output logic        sample_stb,
    output logic        sticky_lost,
    output logic        sticky_oor
`ifdef CLK_RATE_MINMAX_EN
    ,
    output logic [31:0] min_count,
    output logic [31:0] max_count
`endif
);

    localparam int               TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [32:0]      WIN_LO  = window_lo(32'(EXP_COUNT), 32'(TOL_COUNT));
    localparam logic [32:0]      WIN_HI  = window_hi(32'(EXP_COUNT), 32'(TOL_COUNT));
    localparam logic [CTR_W-1:0] GOOD_TH = CTR_W'(GOOD_N);
    localparam logic [CTR_W-1:0] BAD_TH  = CTR_W'(BAD_N);

    logic [TIMER_W-1:0] timer;
    logic               terminal;
    logic               eval;
    logic [31:0]        sample_q;
    class_t             cls;
    state_t             state_q, state_d;
    logic [CTR_W-1:0]   good_q, good_d;
    logic [CTR_W-1:0]   bad_q, bad_d;
    logic               lost_evt;
    logic               oor_evt;

    assign terminal = (timer == TIMER_LAST);

    always_ff @(posedge clk100 or posedge async_reset_clktest) begin
        if (async_reset_clktest) begin
            timer <= '0;
        end else if (terminal) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    clk_rate_classify u_classify (
        .clk100              (clk100),
        .async_reset_clktest (async_reset_clktest),
        .sample_en           (terminal),
        .sample              (value_in),
        .lo                  (WIN_LO),
        .hi                  (WIN_HI),
        .valid               (eval),
        .sample_q            (sample_q),
        .sample_class        (cls)
    );

    always_ff @(posedge clk100 or posedge async_reset_clktest) begin
        if (async_reset_clktest) begin
            state_q <= ST_UNKNOWN;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    // Debounce: GOOD_N in-range samples to enter GOOD, BAD_N out-of-range samples to leave it.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (eval) begin
            unique case (cls)
                CLS_INVALID: begin
                    state_d = ST_UNKNOWN;
                    good_d  = '0;
                    bad_d   = '0;
                end
                CLS_ZERO: begin
                    state_d = ST_DEAD;
                    good_d  = '0;
                    bad_d   = '0;
                end
                CLS_INRANGE: begin
                    case (state_q)
                        ST_LOCKING: begin
                            good_d = sat_inc(good_q);
                            if (good_d >= GOOD_TH) begin
                                state_d = ST_GOOD;
                                bad_d   = '0;
                            end
                        end
                        ST_GOOD: bad_d = '0;
                        default: begin
                            good_d = 4'd1;
                            if (GOOD_TH <= 4'd1) begin
                                state_d = ST_GOOD;
                                bad_d   = '0;
                            end else begin
                                state_d = ST_LOCKING;
                            end
                        end
                    endcase
                end
                CLS_OOR: begin
                    if (state_q == ST_GOOD) begin
                        bad_d = sat_inc(bad_q);
                        if (bad_d >= BAD_TH) begin
                            state_d = ST_BAD;
                            good_d  = '0;
                        end
                    end else begin
                        state_d = ST_BAD;
                        good_d  = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state      = state_q;
        clk_ok     = (state_q == ST_GOOD);
        clk_dead   = (state_q == ST_DEAD);
        sample_stb = eval;
        oor_evt    = eval && (cls == CLS_OOR);
        lost_evt   = (state_q == ST_GOOD) && ((state_d == ST_BAD) || (state_d == ST_DEAD));
    end

    // A set event in the same cycle as clear_sticky takes priority.
    always_ff @(posedge clk100 or posedge async_reset_clktest) begin
        if (async_reset_clktest) begin
            sticky_lost <= 1'b0;
            sticky_oor  <= 1'b0;
            last_count  <= '0;
        end else begin
            if (lost_evt) begin
                sticky_lost <= 1'b1;
            end else if (clear_sticky) begin
                sticky_lost <= 1'b0;
            end
            if (oor_evt) begin
                sticky_oor <= 1'b1;
            end else if (clear_sticky) begin
                sticky_oor <= 1'b0;
            end
            if (eval && (cls != CLS_INVALID)) begin
                last_count <= sample_q;
            end
        end
    end

`ifdef CLK_RATE_MINMAX_EN
    logic [31:0] min_base;
    logic [31:0] max_base;

    // clear_sticky reloads the trackers; a coincident sample then lands on the reloaded values.
    always_comb begin
        min_base = clear_sticky ? RATE_UNMEASURED : min_count;
        max_base = clear_sticky ? 32'd0           : max_count;
    end

    always_ff @(posedge clk100 or posedge async_reset_clktest) begin
        if (async_reset_clktest) begin
            min_count <= RATE_UNMEASURED;
            max_count <= '0;
        end else if (eval && (cls != CLS_INVALID)) begin
            min_count <= (sample_q < min_base) ? sample_q : min_base;
            max_count <= (sample_q > max_base) ? sample_q : max_base;
        end else begin
            min_count <= min_base;
            max_count <= max_base;
        end
    end
`endif

endmodule

// File: tb/tb_clk_rate_checker.sv
// Scoreboard bench for clk_rate_checker with a shortened sample period.
// Stimulus pushes hand-computed expectations; a monitor pops one per sample_stb and checks the outputs.
module tb_clk_rate_checker;

    localparam int unsigned PERIOD = 16;

    logic        clk100 = 1'b0;
    logic        async_reset_clktest = 1'b1;
    logic [31:0] value_in = 32'hFFFF_FFFF;
    logic        clear_sticky = 1'b0;
    logic        clk_ok;
    logic        clk_dead;
    logic [2:0]  state;
    logic [31:0] last_count;
    logic        sample_stb;
    logic        sticky_lost;
    logic        sticky_oor;
`ifdef CLK_RATE_MINMAX_EN
    logic [31:0] min_count;
    logic [31:0] max_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [31:0] last;
        logic        lost;
        logic        oor;
    } exp_t;

    exp_t sb[$];

    clk_rate_checker #(
        .SAMPLE_PERIOD (PERIOD),
        .EXP_COUNT     (1000000),
        .TOL_COUNT     (10000),
        .GOOD_N        (3),
        .BAD_N         (2)
    ) dut (
        .clk100              (clk100),
        .async_reset_clktest (async_reset_clktest),
        .value_in            (value_in),
        .clear_sticky        (clear_sticky),
        .clk_ok              (clk_ok),
        .clk_dead            (clk_dead),
        .state               (state),
        .last_count          (last_count),
        .sample_stb          (sample_stb),
        .sticky_lost         (sticky_lost),
        .sticky_oor          (sticky_oor)
`ifdef CLK_RATE_MINMAX_EN
        ,
        .min_count           (min_count),
        .max_count           (max_count)
`endif
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, got, got, want, want);
        end
    endtask

    // Monitor: outputs settle one cycle after the evaluation cycle flagged by sample_stb.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk100);
            if (sample_stb === 1'b1) begin
                @(negedge clk100);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: sample_stb with no expectation queued, state=%0d", state);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_state"},    32'(state),      32'(e.st));
                    check({e.tag, "_clk_ok"},   32'(clk_ok),     32'(e.st == 3'd2));
                    check({e.tag, "_clk_dead"}, 32'(clk_dead),   32'(e.st == 3'd4));
                    check({e.tag, "_last"},     last_count,      e.last);
                    check({e.tag, "_lost"},     32'(sticky_lost), 32'(e.lost));
                    check({e.tag, "_oor"},      32'(sticky_oor),  32'(e.oor));
                end
            end
        end
    end

    task automatic do_sample(input string tag, input logic [31:0] v, input logic [2:0] st,
                             input logic [31:0] last, input logic lost, input logic oor,
                             input logic clr_at_eval, output int cycles);
        exp_t e;
        value_in = v;
        e.tag  = tag;
        e.st   = st;
        e.last = last;
        e.lost = lost;
        e.oor  = oor;
        sb.push_back(e);
        cycles = -1;
        for (int i = 1; i <= 4 * PERIOD; i++) begin
            @(negedge clk100);
            if (sample_stb === 1'b1) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no sample_stb within %0d cycles, expected one", tag, 4 * PERIOD);
        end
        if (clr_at_eval) clear_sticky = 1'b1;
        @(negedge clk100);
        clear_sticky = 1'b0;
    endtask

    task automatic samp(input string tag, input logic [31:0] v, input logic [2:0] st,
                        input logic [31:0] last, input logic lost, input logic oor);
        int c;
        do_sample(tag, v, st, last, lost, oor, 1'b0, c);
    endtask

    task automatic pulse_clear();
        @(negedge clk100);
        clear_sticky = 1'b1;
        @(negedge clk100);
        clear_sticky = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},  32'(state),       32'd0);
        check({tag, "_clk_ok"}, 32'(clk_ok),      32'd0);
        check({tag, "_dead"},   32'(clk_dead),    32'd0);
        check({tag, "_last"},   last_count,       32'd0);
        check({tag, "_stb"},    32'(sample_stb),  32'd0);
        check({tag, "_lost"},   32'(sticky_lost), 32'd0);
        check({tag, "_oor"},    32'(sticky_oor),  32'd0);
`ifdef CLK_RATE_MINMAX_EN
        check({tag, "_min"},    min_count,        32'hFFFF_FFFF);
        check({tag, "_max"},    max_count,        32'd0);
`endif
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk100);
        check_reset_values("por");
        async_reset_clktest = 1'b0;

        // Unmeasured word held: stays UNKNOWN; first strobe PERIOD cycles after reset release.
        do_sample("inv1", 32'hFFFF_FFFF, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, lat);
        check("first_stb_latency", 32'(lat), 32'(PERIOD));
        samp("inv2", 32'hFFFF_FFFF, 3'd0, 32'd0, 1'b0, 1'b0);
        samp("inv3", 32'hFFFF_FFFF, 3'd0, 32'd0, 1'b0, 1'b0);

        // Lock up with nominal rate.
        samp("lock1", 32'd1000000, 3'd1, 32'd1000000, 1'b0, 1'b0);
        samp("lock2", 32'd1000000, 3'd1, 32'd1000000, 1'b0, 1'b0);
        samp("lock3", 32'd1000000, 3'd2, 32'd1000000, 1'b0, 1'b0);

        // Single out-of-range glitch is absorbed.
        samp("glitch",  32'd1020000, 3'd2, 32'd1020000, 1'b0, 1'b1);
        samp("recover", 32'd1000000, 3'd2, 32'd1000000, 1'b0, 1'b1);

        // Two consecutive low samples leave GOOD.
        samp("low1", 32'd980000, 3'd2, 32'd980000, 1'b0, 1'b1);
        samp("low2", 32'd980000, 3'd3, 32'd980000, 1'b1, 1'b1);
        pulse_clear();

        samp("relock1", 32'd1000000, 3'd1, 32'd1000000, 1'b0, 1'b0);
        samp("relock2", 32'd1000000, 3'd1, 32'd1000000, 1'b0, 1'b0);
        samp("relock3", 32'd1000000, 3'd2, 32'd1000000, 1'b0, 1'b0);

        // Window edges.
        samp("edge_lo_in",  32'd990000,  3'd2, 32'd990000,  1'b0, 1'b0);
        samp("edge_hi_in",  32'd1010000, 3'd2, 32'd1010000, 1'b0, 1'b0);
        samp("edge_lo_out", 32'd989999,  3'd2, 32'd989999,  1'b0, 1'b1);
        samp("edge_hi_out", 32'd1010001, 3'd3, 32'd1010001, 1'b1, 1'b1);

        samp("relock4", 32'd1000000, 3'd1, 32'd1000000, 1'b1, 1'b1);
        samp("relock5", 32'd1000000, 3'd1, 32'd1000000, 1'b1, 1'b1);
        samp("relock6", 32'd1000000, 3'd2, 32'd1000000, 1'b1, 1'b1);

        // clear_sticky in the evaluation cycle of an OOR sample: oor set wins, lost clears.
        do_sample("set_wins", 32'd1020000, 3'd2, 32'd1020000, 1'b0, 1'b1, 1'b1, lat);

        // Zero rate from GOOD goes DEAD and flags the loss.
        samp("dead",      32'd0,           3'd4, 32'd0, 1'b1, 1'b1);
        samp("dead_inv",  32'hFFFF_FFFF,   3'd0, 32'd0, 1'b1, 1'b1);
        samp("pre_reset", 32'd1000000,     3'd1, 32'd1000000, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a period.
        repeat (5) @(negedge clk100);
        #2;
        async_reset_clktest = 1'b1;
        #1;
        check_reset_values("mid_reset");
        repeat (2) @(negedge clk100);
        async_reset_clktest = 1'b0;
        do_sample("post_reset", 32'hFFFF_FFFF, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, lat);
        check("post_reset_stb_latency", 32'(lat), 32'(PERIOD));

        samp("mm1", 32'd995000,  3'd1, 32'd995000,  1'b0, 1'b0);
        samp("mm2", 32'd1005000, 3'd1, 32'd1005000, 1'b0, 1'b0);
`ifdef CLK_RATE_MINMAX_EN
        check("min_count", min_count, 32'd995000);
        check("max_count", max_count, 32'd1005000);
`endif

        repeat (3) @(negedge clk100);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
